mem_arbiter: RTL
================

# mem_arbiter

Shares the single-ported unified instruction/data memory of the tinyRISC processor between the fetch stage and the load/store stage. Each side raises a held request. The arbiter grants one requester and sequences the memory access over a fixed read latency, then returns a one-cycle response. Data requests take priority, and a starvation guard guarantees fetch progress. The block sits between `processor` and the memory array, replacing direct memory wiring.

## Interface
Parameters:
- `ADDR_W`, 8: memory address width (256 words).
- `DATA_W`, 16: memory word width.
- `MEM_LAT`, 1: memory read latency in cycles after `mem_en`. Legal range 1..7.
- `STARVE_MAX`, 3: maximum consecutive data grants while fetch waits.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_gnt`  out  1  fetch accepted; single-cycle pulse.
- `if_rvalid`  out  1  fetch data valid; single-cycle pulse.
- `if_rdata`  out  DATA_W  fetched word.
- `d_req`  in  1  data request; held with payload until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_gnt`  out  1  data accepted; single-cycle pulse.
- `d_rvalid`  out  1  data transaction complete; single-cycle pulse.
- `d_rdata`  out  DATA_W  load data; 0 for stores.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable; only ever high together with `mem_en`.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; valid `MEM_LAT` cycles after `mem_en`.
- `busy`  out  1  high in every state except IDLE.

## Operation
State machine:
- **IDLE.** If any request is present, pick a winner, assert its `gnt` combinationally, latch addr/we/wdata, then go to ACCESS. With no request, stay in IDLE.
- **ACCESS.** Drive `mem_en` = 1 plus the latched we/addr/wdata for exactly one cycle, then go to WAIT.
- **WAIT.** Count `MEM_LAT` cycles. In the last cycle, capture `mem_rdata` (or 0 for a store), then go to RESP.
- **RESP.** Pulse the owner's `rvalid` with the captured data and return to IDLE. This state is merged into the IDLE entry cycle; see Timing.

Priority:
- Data wins over fetch by default.
- Starvation counter `streak` (width clog2(STARVE_MAX+1)):
  - increments on a data grant while `if_req` = 1;
  - clears on any fetch grant, and on a data grant while `if_req` = 0.
- When both requesters are present and `streak` == `STARVE_MAX`, fetch wins.

Request and grant rules:
- Grants are issued only in IDLE; at most one grant per cycle.
- A request dropped before its grant is legal; nothing is latched for it.
- Stores follow the same schedule as loads; `d_rvalid` confirms the write.

Outputs:
- Only the transaction owner's `rvalid`/`rdata` change on a response.
- The other requester's `rdata` holds its last value.
- `mem_addr`/`mem_wdata` hold their last value when `mem_en` = 0.

Reset:
- Asserting reset clears all state and outputs to 0 (`streak` = 0, state IDLE), at any time.
- An in-flight transaction is dropped; no `rvalid` is issued for it, and the requester must re-request.

## Timing
For a grant in cycle T:
- `mem_en` is high in T+1.
- `mem_rdata` is sampled in T+1+MEM_LAT.
- `rvalid` is high in T+2+MEM_LAT.

The arbiter is back in IDLE during the `rvalid` cycle, so a new grant may coincide with `rvalid`. Sustained throughput is one transaction per MEM_LAT+2 cycles.

Simultaneous events:
- `if_req` and `d_req` rising in the same cycle: decided by the priority rule above.
- A request arriving in the cycle the arbiter returns to IDLE: granted that same cycle.

## Structure
- Shared package `tinyrisc_pkg`:
  - `ADDR_W` and `DATA_W` defaults;
  - `arb_state_t` enum (IDLE, ACCESS, WAIT);
  - `arb_owner_t` enum (OWN_IF, OWN_D).
- No sub-module: the priority pick, latency counter and starvation counter are small enough to stay inline.

## Test plan
- **Reset.** Hold reset low 3 cycles with both requests high → all outputs 0, no `gnt`. Release reset → `d_gnt` in the first cycle.
- **Fetch read (MEM_LAT=1).** `if_req`, `if_addr`=0x10, memory[0x10]=0xA5C3 → `if_gnt` at T, `mem_en` at T+1, `if_rvalid`=1 with `if_rdata`=0xA5C3 at T+3.
- **Store then load.** `d_we`=1, addr 0x20, data 0x1234; then a load from 0x20 → second `d_rvalid` returns 0x1234; `mem_we` is high only in the store's ACCESS cycle.
- **Starvation.** `if_req` and `d_req` held continuously, STARVE_MAX=3 → grant sequence D,D,D,I,D,D,D,I.
- **Latency sweep.** Repeat the fetch read with MEM_LAT=4 → `rvalid` at T+6; `busy` is high from T+1 through T+5.
- **Mid-operation reset.** Assert reset in a WAIT cycle → no `rvalid`. A re-request after release completes normally.

Source files
------------

// File: rtl/tinyrisc_pkg.sv
// Shared tinyRISC definitions: default bus widths and the memory arbiter's
// state and owner encodings.
package tinyrisc_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  // Starvation counter must reach max_grants itself, so it needs one more code.
  function automatic int streak_width(input int max_grants);
    return (max_grants < 1) ? 1 : $clog2(max_grants + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the memory port that the
// arbiter sits between. slave is the arbiter's view, master is everyone else.
interface mem_arbiter_if #(
  parameter int ADDR_W = tinyrisc_pkg::DEF_ADDR_W,
  parameter int DATA_W = tinyrisc_pkg::DEF_DATA_W
) ();

  // fetch side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // load/store side
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // memory side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req,
    input  if_addr,
    output if_gnt,
    output if_rvalid,
    output if_rdata,
    input  d_req,
    input  d_we,
    input  d_addr,
    input  d_wdata,
    output d_gnt,
    output d_rvalid,
    output d_rdata,
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req,
    output if_addr,
    input  if_gnt,
    input  if_rvalid,
    input  if_rdata,
    output d_req,
    output d_we,
    output d_addr,
    output d_wdata,
    input  d_gnt,
    input  d_rvalid,
    input  d_rdata,
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and
// load/store: data-first priority with a fetch starvation guard, fixed latency.
module mem_arbiter
  import tinyrisc_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus,
  output logic         busy
);

  localparam int                SW         = streak_width(STARVE_MAX);
  localparam logic [SW-1:0]     STREAK_LIM = SW'(STARVE_MAX);
  localparam logic [2:0]        LAT_LAST   = 3'(MEM_LAT);

  arb_state_t        state_reg,     state_next;
  arb_owner_t        owner_reg,     owner_next;
  logic              we_reg,        we_next;
  logic [ADDR_W-1:0] addr_reg,      addr_next;
  logic [DATA_W-1:0] wdata_reg,     wdata_next;
  logic [2:0]        lat_reg,       lat_next;
  logic [SW-1:0]     streak_reg,    streak_next;
  logic              if_rvalid_reg, if_rvalid_next;
  logic              d_rvalid_reg,  d_rvalid_next;
  logic [DATA_W-1:0] if_rdata_reg,  if_rdata_next;
  logic [DATA_W-1:0] d_rdata_reg,   d_rdata_next;

  logic if_gnt;
  logic d_gnt;
  logic fetch_forced;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_IF;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      lat_reg       <= '0;
      streak_reg    <= '0;
      if_rvalid_reg <= 1'b0;
      d_rvalid_reg  <= 1'b0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      lat_reg       <= lat_next;
      streak_reg    <= streak_next;
      if_rvalid_reg <= if_rvalid_next;
      d_rvalid_reg  <= d_rvalid_next;
      if_rdata_reg  <= if_rdata_next;
      d_rdata_reg   <= d_rdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    we_next        = we_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    lat_next       = lat_reg;
    streak_next    = streak_reg;
    if_rdata_next  = if_rdata_reg;
    d_rdata_next   = d_rdata_reg;
    if_rvalid_next = 1'b0;
    d_rvalid_next  = 1'b0;
    if_gnt         = 1'b0;
    d_gnt          = 1'b0;
    fetch_forced   = bus.if_req && (streak_reg == STREAK_LIM);

    unique case (state_reg)
      IDLE: begin
        // grants are combinational, so they must stay low while reset is held
        if (reset) begin
          if (bus.d_req && !fetch_forced) begin
            d_gnt       = 1'b1;
            owner_next  = OWN_D;
            we_next     = bus.d_we;
            addr_next   = bus.d_addr;
            wdata_next  = bus.d_wdata;
            streak_next = bus.if_req ? streak_reg + SW'(1) : '0;
            state_next  = ACCESS;
          end else if (bus.if_req) begin
            if_gnt      = 1'b1;
            owner_next  = OWN_IF;
            we_next     = 1'b0;
            addr_next   = bus.if_addr;
            streak_next = '0;
            state_next  = ACCESS;
          end
        end
      end

      ACCESS: begin
        lat_next   = 3'd1;
        state_next = WAIT;
      end

      WAIT: begin
        if (lat_reg == LAT_LAST) begin
          // the response pulse lands in the IDLE cycle that follows
          state_next = IDLE;
          if (owner_reg == OWN_D) begin
            d_rvalid_next = 1'b1;
            d_rdata_next  = we_reg ? '0 : bus.mem_rdata;
          end else begin
            if_rvalid_next = 1'b1;
            if_rdata_next  = bus.mem_rdata;
          end
        end else begin
          lat_next = lat_reg + 3'd1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.if_rvalid = if_rvalid_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.d_rvalid  = d_rvalid_reg;
  assign bus.d_rdata   = d_rdata_reg;

  assign bus.mem_en    = (state_reg == ACCESS);
  assign bus.mem_we    = (state_reg == ACCESS) && we_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;

  assign busy = (state_reg != IDLE);

endmodule
